// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bin2bcd_pkg;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam int         DIG_W       = 4;
   localparam logic [3:0] ADD3_THRESH = 4'd5;
   localparam logic [3:0] SAT_DIG     = 4'd9;
endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [DIG_W-1:0] i_dig,
   output logic [DIG_W-1:0] o_dig
);
   assign o_dig = (i_dig >= ADD3_THRESH) ? i_dig + DIG_W'(3) : i_dig;
endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential double-dabble converter: one operand bit per cycle, with a saturating
// N_DIG-digit result and an overflow flag.
module bin2bcd_conv
   import bin2bcd_pkg::*;
#(
   parameter int W_BIN = 16,
   parameter int N_DIG = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [W_BIN-1:0]   bin,
   output logic               busy,
   output logic               done,
   output logic [4*N_DIG-1:0] bcd,
   output logic               ovf
);
   localparam int ACC_W = DIG_W*(N_DIG+1);
   localparam int CNT_W = $clog2(W_BIN+1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [W_BIN-1:0]   r_op;
   logic [ACC_W-1:0]   r_acc;
   logic               r_lost;
   logic               r_busy;
   logic               r_done;
   logic [4*N_DIG-1:0] r_bcd;
   logic               r_ovf;

   logic [ACC_W-1:0]   w_adj;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic               w_lost_nxt;
   logic               w_ovf;

   for (genvar g = 0; g <= N_DIG; g++) begin : g_dig
      bcd_digit_adj u_adj (
         .i_dig (r_acc[g*DIG_W +: DIG_W]),
         .o_dig (w_adj[g*DIG_W +: DIG_W])
      );
   end

   // A bit pushed out of the top digit is remembered so narrow N_DIG still flags overflow.
   assign w_acc_nxt  = {w_adj[ACC_W-2:0], r_op[W_BIN-1]};
   assign w_lost_nxt = r_lost | w_adj[ACC_W-1];
   assign w_ovf      = w_lost_nxt | (|w_acc_nxt[ACC_W-1 -: DIG_W]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_acc   <= '0;
         r_lost  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_bcd   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op    <= bin;
                  r_acc   <= '0;
                  r_lost  <= 1'b0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_acc  <= w_acc_nxt;
               r_op   <= {r_op[W_BIN-2:0], 1'b0};
               r_lost <= w_lost_nxt;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(W_BIN-1)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_ovf   <= w_ovf;
                  r_bcd   <= w_ovf ? {N_DIG{SAT_DIG}} : w_acc_nxt[4*N_DIG-1:0];
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign bcd  = r_bcd;
   assign ovf  = r_ovf;
endmodule

// File: tb/tb_bin2bcd_conv.sv
// Randomized scoreboard bench for bin2bcd_conv against a decimal-arithmetic model.
module tb_bin2bcd_conv;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] bin;
   logic        busy, done, ovf;
   logic [15:0] bcd;

   int total = 0;
   int bad   = 0;
   int n_done = 0;
   logic [16:0] sb[$];

   bin2bcd_conv #(.W_BIN(16), .N_DIG(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // {ovf, bcd} from plain decimal arithmetic
   function automatic logic [16:0] model(input int v);
      logic [15:0] r;
      int x;
      if (v > 9999) return {1'b1, 16'h9999};
      r = '0;
      x = v;
      for (int d = 0; d < 4; d++) begin
         r[d*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return {1'b0, r};
   endfunction

   // monitor: pop and compare on every completion pulse
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            logic [16:0] e;
            e = sb.pop_front();
            chk("bcd", 32'(bcd), 32'(e[15:0]));
            chk("ovf", 32'(ovf), 32'(e[16]));
            for (int d = 0; d < 4; d++) chk("digit_range", 32'(bcd[d*4 +: 4] <= 4'd9), 32'd1);
            chk("busy_in_done", 32'(busy), 32'd1);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Called at a negedge; accepted on the following posedge.
   task automatic conv(input logic [15:0] v, input bit poke);
      int lat = 0, nb = 0, n0;
      wait_idle();
      n0 = n_done;
      bin = v;
      start = 1'b1;
      sb.push_back(model(int'(v)));
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            bin = 16'($urandom);
         end
         if (busy) nb++;
         if (done && lat == 0) lat = i;
         if (poke) begin
            start = (i == 3 || i == 17);
            bin = 16'd42;
         end
         if (i == 18) start = 1'b0;
      end
      chk("latency", 32'(lat), 32'd17);
      chk("busy_cycles", 32'(nb), 32'd17);
      chk("one_done", 32'(n_done - n0), 32'd1);
   endtask

   initial begin
      int k, n0, t0;
      int tq[$];
      rst_n = 1'b0;
      start = 1'b0;
      bin = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);

      rst_n = 1'b1;
      conv(16'd0, 1'b0);
      conv(16'h00FF, 1'b0);
      conv(16'h270F, 1'b0);
      conv(16'h2710, 1'b0);
      conv(16'hFFFF, 1'b0);
      conv(16'd9999, 1'b0);
      conv(16'd1234, 1'b1);
      n0 = n_done;
      repeat (20) @(negedge clk);
      chk("no_queued_start", 32'(n_done - n0), 32'd0);

      // abort mid-conversion
      wait_idle();
      n0 = n_done;
      bin = 16'd5000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_bcd", 32'(bcd), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("abort_no_done", 32'(n_done - n0), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
      conv(16'd5000, 1'b0);

      // start held high: back-to-back conversions
      wait_idle();
      for (int j = 0; j < 3; j++) sb.push_back(model(7));
      bin = 16'd7;
      start = 1'b1;
      k = 0;
      t0 = 0;
      for (int i = 0; i < 100 && k < 3; i++) begin
         @(negedge clk);
         if (done) begin
            k++;
            tq.push_back(i);
            if (k == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      chk("held_count", 32'(k), 32'd3);
      if (tq.size() == 3) begin
         chk("held_period0", 32'(tq[1] - tq[0]), 32'd18);
         chk("held_period1", 32'(tq[2] - tq[1]), 32'd18);
      end
      repeat (3) @(negedge clk);

      for (int j = 0; j < 30; j++) conv(16'($urandom_range(0, 65535)), j[0]);
      for (int j = 0; j < 10; j++) conv(16'($urandom_range(9990, 10010)), 1'b0);

      repeat (5) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/bin2bcd_conv.md
BIN2BCD_CONV -- requirements
Module: bin2bcd_conv

Interface
REQ-001 Parameter W_BIN, default 16: binary input width in bits, legal range 4..16.
REQ-002 Parameter N_DIG, default 4: BCD output digits presented to the display stage.
REQ-003 Port clk, input, 1: single system clock (50 MHz via global buffer); all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port start, input, 1: conversion request, sampled only in IDLE.
REQ-006 Port bin, input, W_BIN: unsigned binary operand, captured on the accepting edge.
REQ-007 Port busy, output, 1: high while a conversion is in progress (SHIFT or DONE).
REQ-008 Port done, output, 1: single-cycle completion pulse.
REQ-009 Port bcd, output, 4*N_DIG: packed BCD result, digit 0 in bits [3:0], consumed by DISPLAY as its dat input.
REQ-010 Port ovf, output, 1: result exceeded 10^N_DIG - 1.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE -> SHIFT when start=1 on a rising edge; on that edge bin SHALL be loaded into an internal shift register and the BCD accumulator (N_DIG+1 digits) SHALL be cleared.
REQ-013 In SHIFT, each cycle SHALL perform one double-dabble step: add 3 to every accumulator digit >= 5, then shift accumulator:operand left by one bit.
REQ-014 SHIFT SHALL last exactly W_BIN cycles, counted by an iteration counter of width clog2(W_BIN+1), then transition to DONE.
REQ-015 In DONE, done SHALL be 1 for exactly one cycle; on the DONE->IDLE edge the FSM SHALL return to IDLE unconditionally.
REQ-016 bcd and ovf SHALL be registered and updated only on the SHIFT->DONE edge; they SHALL hold their value until the next completion or reset.
REQ-017 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+W_BIN (W_BIN+1 cycles), and bcd SHALL be valid in that same cycle.
REQ-018 busy SHALL be 1 from the edge after acceptance through the DONE cycle inclusive, and 0 in IDLE.
REQ-019 start asserted while busy=1, including in the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-020 A start held high continuously SHALL begin a new conversion on the first IDLE edge after DONE, giving back-to-back results every W_BIN+2 cycles.
REQ-021 A change on bin after acceptance SHALL NOT affect the result in flight.
REQ-022 Overflow: if the uppermost accumulator digit is nonzero, ovf SHALL be 1 and bcd SHALL saturate to all digits 9; otherwise ovf SHALL be 0 and bcd SHALL equal the low N_DIG digits.
REQ-023 Every output digit SHALL always be in the range 0..9.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state IDLE, clear the iteration counter and shift registers, and set busy=0, done=0, bcd=0, ovf=0.
REQ-025 Reset asserted mid-conversion SHALL abort it with no done pulse; after release the block SHALL wait in IDLE for a fresh start.
REQ-026 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Structure
REQ-027 Package bin2bcd_pkg SHALL hold the state enumeration, the BCD digit width (4), the add-3 threshold (5), and the saturate digit value (9).
REQ-028 The per-digit conditional add-3 SHALL be a sub-module bcd_digit_adj, instantiated N_DIG+1 times.
REQ-029 The block SHALL use no multipliers or dividers; its RTL SHALL be 120-400 lines.

Verification
REQ-030 bin=0, start pulse -> after 17 cycles done=1, bcd=16'h0000, ovf=0.
REQ-031 bin=16'h00FF -> bcd=16'h0255, ovf=0; bin=16'h270F -> bcd=16'h9999, ovf=0.
REQ-032 bin=16'h2710 (10000) -> bcd=16'h9999, ovf=1; bin=16'hFFFF -> bcd=16'h9999, ovf=1.
REQ-033 bin=1234 accepted, then start=1 with bin=42 at cycles 3 and 17 -> exactly one done pulse, bcd=16'h1234, busy=1 for 17 cycles.
REQ-034 rst_n pulsed low at SHIFT cycle 8 of bin=5000 -> no done pulse, bcd=0, busy=0; next start with bin=5000 -> bcd=16'h5000.
REQ-035 start held high with bin=7 -> done pulses every 18 cycles, bcd=16'h0007 each time.
